// File: rtl/pal_cfg_pkg.sv
// Shared state encoding, byte width and sizing helpers for the PAL
// configuration loader.
package pal_cfg_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GET   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CHK   = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  function automatic int calc_nbytes(input int len);
    return (len + BYTE_W - 1) / BYTE_W;
  endfunction

  // Pad bits sit at the top of the first byte and are never shifted.
  function automatic int calc_pad(input int len);
    return calc_nbytes(len) * BYTE_W - len;
  endfunction

  function automatic logic [BYTE_W-1:0] csum_update(input logic [BYTE_W-1:0] csum,
                                                    input logic [BYTE_W-1:0] data);
    return csum ^ data;
  endfunction

endpackage

// File: rtl/pal_cfg_loader_if.sv
// Byte stream valid/ready handshake into the configuration loader.
interface pal_cfg_loader_if;
  import pal_cfg_pkg::*;

  logic [BYTE_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);

endinterface

// File: rtl/pal_cfg_ser.sv
// Byte serialiser: shifts the low nbits of a byte MSB-first, each bit as a
// cfg_clk-low phase followed by a cfg_clk-high phase.
module pal_cfg_ser
  import pal_cfg_pkg::*;
(
  input  logic              clk,
  input  logic              res_n,
  input  logic              clear,
  input  logic              start,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic [3:0]        nbits,
  output logic              cfg,
  output logic              cfg_clk,
  output logic              done
);

  logic [BYTE_W-1:0] byte_r;
  logic [2:0]        bit_idx_r;
  logic              active_r;
  logic              cfg_r;
  logic              cfg_clk_r;
  logic [2:0]        first_idx_s;

  assign first_idx_s = 3'(nbits - 4'd1);

  // Phase toggle and bit counter; cfg only changes while cfg_clk is low.
  always_ff @(posedge clk) begin
    if (!res_n || clear) begin
      byte_r    <= 8'h00;
      bit_idx_r <= 3'd0;
      active_r  <= 1'b0;
      cfg_r     <= 1'b0;
      cfg_clk_r <= 1'b0;
    end else if (start) begin
      byte_r    <= byte_in;
      bit_idx_r <= first_idx_s;
      cfg_r     <= byte_in[first_idx_s];
      cfg_clk_r <= 1'b0;
      active_r  <= 1'b1;
    end else if (active_r) begin
      if (!cfg_clk_r) begin
        cfg_clk_r <= 1'b1;
      end else begin
        cfg_clk_r <= 1'b0;
        if (bit_idx_r == 3'd0) begin
          active_r <= 1'b0;
        end else begin
          bit_idx_r <= bit_idx_r - 3'd1;
          cfg_r     <= byte_r[bit_idx_r - 3'd1];
        end
      end
    end
  end

  assign done    = active_r && cfg_clk_r && (bit_idx_r == 3'd0);
  assign cfg     = cfg_r;
  assign cfg_clk = cfg_clk_r;

endmodule

// File: rtl/pal_cfg_loader.sv
// Feeds the PAL configuration chain from a byte stream and releases it via en
// only after a complete load whose trailing XOR checksum matches.
module pal_cfg_loader
  import pal_cfg_pkg::*;
#(
  parameter int LEN = 8
)
(
  input  logic            clk,
  input  logic            res_n,
  input  logic            load,
  pal_cfg_loader_if.slave bus,
  output logic            cfg_clk,
  output logic            cfg,
  output logic            en,
  output logic            busy,
  output logic            err
);

  localparam int NBYTES = calc_nbytes(LEN);
  localparam int PAD    = calc_pad(LEN);
  localparam int IDX_W  = $clog2(NBYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NBYTES - 1);
  localparam logic [3:0]       FIRST_NBITS = 4'(BYTE_W - PAD);

  state_e            state_r, next_state_s;
  logic [BYTE_W-1:0] csum_r, csum_s;
  logic [IDX_W-1:0]  idx_r, idx_s;
  logic              en_r, en_s;
  logic              busy_r, busy_s;
  logic              err_r, err_s;
  logic              ready_r, ready_s;
  logic              ser_start_s, ser_clear_s, ser_done_s;
  logic [3:0]        ser_nbits_s;

  pal_cfg_ser u_ser (
    .clk     (clk),
    .res_n   (res_n),
    .clear   (ser_clear_s),
    .start   (ser_start_s),
    .byte_in (bus.data_in),
    .nbits   (ser_nbits_s),
    .cfg     (cfg),
    .cfg_clk (cfg_clk),
    .done    (ser_done_s)
  );

  // Next-state logic; load overrides everything, so a byte offered alongside it is dropped.
  always_comb begin
    next_state_s = state_r;
    csum_s       = csum_r;
    idx_s        = idx_r;
    en_s         = en_r;
    busy_s       = busy_r;
    err_s        = err_r;
    ser_start_s  = 1'b0;
    ser_clear_s  = 1'b0;
    ser_nbits_s  = 4'(BYTE_W);
    if (load) begin
      next_state_s = ST_GET;
      csum_s       = 8'h00;
      idx_s        = {IDX_W{1'b0}};
      en_s         = 1'b0;
      busy_s       = 1'b1;
      err_s        = 1'b0;
      ser_clear_s  = 1'b1;
    end else begin
      case (state_r)
        ST_GET: begin
          if (bus.data_valid && ready_r) begin
            csum_s       = csum_update(csum_r, bus.data_in);
            ser_start_s  = 1'b1;
            ser_nbits_s  = (idx_r == {IDX_W{1'b0}}) ? FIRST_NBITS : 4'(BYTE_W);
            next_state_s = ST_SHIFT;
          end else begin
            next_state_s = ST_GET;
          end
        end
        ST_SHIFT: begin
          if (ser_done_s) begin
            idx_s        = idx_r + IDX_W'(1);
            next_state_s = (idx_r == LAST_IDX) ? ST_CHK : ST_GET;
          end else begin
            next_state_s = ST_SHIFT;
          end
        end
        ST_CHK: begin
          if (bus.data_valid && ready_r) begin
            busy_s = 1'b0;
            if (bus.data_in == csum_r) begin
              next_state_s = ST_DONE;
              en_s         = 1'b1;
            end else begin
              next_state_s = ST_ERR;
              err_s        = 1'b1;
              en_s         = 1'b0;
            end
          end else begin
            next_state_s = ST_CHK;
          end
        end
        ST_IDLE, ST_DONE, ST_ERR: begin
          next_state_s = state_r;
        end
        default: begin
          next_state_s = ST_IDLE;
        end
      endcase
    end
    ready_s = (next_state_s == ST_GET) || (next_state_s == ST_CHK);
  end

  // State and registered status outputs.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_r <= ST_IDLE;
      csum_r  <= 8'h00;
      idx_r   <= {IDX_W{1'b0}};
      en_r    <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
      ready_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      csum_r  <= csum_s;
      idx_r   <= idx_s;
      en_r    <= en_s;
      busy_r  <= busy_s;
      err_r   <= err_s;
      ready_r <= ready_s;
    end
  end

  assign bus.data_ready = ready_r;
  assign en             = en_r;
  assign busy           = busy_r;
  assign err            = err_r;

endmodule
